// File: rtl/led_sweeper_if.sv
// led_sweeper_if: control inputs and LED/position outputs of the LED sweeper
interface led_sweeper_if #(
    parameter int WIDTH = 16
) ();
    localparam int PW = $clog2(WIDTH);
    logic en;
    logic m_tick;
    logic [1:0] mode;
    logic load;
    logic [PW-1:0] load_pos;
    logic [WIDTH-1:0] out;
    logic [PW-1:0] pos;
    logic dir;
    logic sweep_done;
    modport master (
        output en, m_tick, mode, load, load_pos,
        input  out, pos, dir, sweep_done
    );
    modport slave (
        input  en, m_tick, mode, load, load_pos,
        output out, pos, dir, sweep_done
    );
endinterface

// File: rtl/led_sweeper.sv
// led_sweeper: one-lit LED sweep with bounce/rotate/hold modes and a cycle-completion pulse
// Defining LED_SWEEPER_TRAIL_EN adds a registered prev_pos that lights a trailing LED
module led_sweeper #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    led_sweeper_if.slave bus
);
    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
    logic [PW-1:0] pos, pos_n, load_val, step_pos;
    logic dir, dir_n, done, done_n, step, up;
    assign load_val = bus.load_pos > LAST ? LAST : bus.load_pos;
    assign step = bus.en && bus.m_tick && !bus.load && bus.mode != 2'b11;
    // bounce direction for this step: turn around at either end without dwelling
    assign up = dir ? pos == '0 : pos != LAST;
    always_comb begin
        step_pos = bus.mode == 2'b00 ? (up ? pos + PW'(1) : pos - PW'(1)) :
                   bus.mode == 2'b01 ? (pos == LAST ? '0 : pos + PW'(1)) :
                   (pos == '0 ? LAST : pos - PW'(1));
        pos_n = bus.load ? load_val : step ? step_pos : pos;
        dir_n = bus.load ? 1'b0 : step ? (bus.mode == 2'b00 ? !up : bus.mode == 2'b10) : dir;
        done_n = step && (bus.mode == 2'b00 ? pos == PW'(1) && !up :
                          bus.mode == 2'b01 ? pos == LAST : pos == '0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pos  <= '0;
            dir  <= 1'b0;
            done <= 1'b0;
        end else begin
            pos  <= pos_n;
            dir  <= dir_n;
            done <= done_n;
        end
    end
    assign bus.pos = pos;
    assign bus.dir = dir;
    assign bus.sweep_done = done;
`ifdef LED_SWEEPER_TRAIL_EN
    logic [PW-1:0] prev_pos;
    always_ff @(posedge clk) begin
        if (reset) prev_pos <= '0;
        else if (bus.load) prev_pos <= load_val;
        else if (step) prev_pos <= pos;
    end
    assign bus.out = (WIDTH'(1) << pos) | (WIDTH'(1) << prev_pos);
`else
    assign bus.out = WIDTH'(1) << pos;
`endif
endmodule
